// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: byte FIFO, baud-rate divider and frame FSM driving tx_out.
// Define TX_PARITY_EN to build the parity bit (odd/even from odd_parity); otherwise frames carry no parity.
module uart_tx_sequencer #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_en,
    input  logic                          two_stop,
    input  logic                          odd_parity,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP1,
        ST_STOP2
    } state_t;

    // FIFO storage and pointers
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    // Frame FSM state
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] baud_reg, baud_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             two_stop_reg, two_stop_next;
    logic             tx_out_reg, tx_out_next;
    logic             tx_done_reg, tx_done_next;
    logic             frame_end;
`ifdef TX_PARITY_EN
    logic             parity_reg, parity_next;
`else
    logic             unused_odd_parity;
    assign unused_odd_parity = odd_parity;
`endif

    // Full is judged on the registered count, so a pop never frees a slot in the same cycle.
    assign wr_ready = (count_reg != FIFO_FULL);
    assign push     = wr_valid && wr_ready;
    assign head     = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            two_stop_reg <= 1'b0;
            tx_out_reg   <= 1'b1;
            tx_done_reg  <= 1'b0;
`ifdef TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            two_stop_reg <= two_stop_next;
            tx_out_reg   <= tx_out_next;
            tx_done_reg  <= tx_done_next;
`ifdef TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        two_stop_next = two_stop_reg;
        tx_done_next  = 1'b0;
        tx_out_next   = 1'b1;
        frame_end     = 1'b0;
        pop           = 1'b0;
`ifdef TX_PARITY_EN
        parity_next   = parity_reg;
`endif

        if (state_reg != ST_IDLE) begin
            if (baud_reg == BAUD_LAST) begin
                baud_next = '0;
                case (state_reg)
                    ST_START: begin
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                    end
                    ST_DATA: begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7) begin
`ifdef TX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP1;
`endif
                        end
                    end
`ifdef TX_PARITY_EN
                    ST_PARITY: state_next = ST_STOP1;
`endif
                    ST_STOP1: begin
                        if (two_stop_reg) begin
                            state_next = ST_STOP2;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end
                    ST_STOP2: frame_end = 1'b1;
                    default:  state_next = ST_IDLE;
                endcase
            end else begin
                baud_next = baud_reg + 1'b1;
            end
        end

        if (frame_end) begin
            tx_done_next = 1'b1;
            state_next   = ST_IDLE;
        end

        // A new frame starts from IDLE or straight off the last stop bit, with no idle gap.
        if ((state_reg == ST_IDLE || frame_end) && tx_en && (count_reg != '0)) begin
            pop           = 1'b1;
            shift_next    = head;
            two_stop_next = two_stop;
            baud_next     = '0;
            bit_idx_next  = '0;
            state_next    = ST_START;
`ifdef TX_PARITY_EN
            parity_next   = (^head) ^ odd_parity;
`endif
        end

        case (state_next)
            ST_START:  tx_out_next = 1'b0;
            ST_DATA:   tx_out_next = shift_next[0];
`ifdef TX_PARITY_EN
            ST_PARITY: tx_out_next = parity_next;
`endif
            default:   tx_out_next = 1'b1;
        endcase
    end

    assign tx_out     = tx_out_reg;
    assign tx_done    = tx_done_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Randomized bench for uart_tx_sequencer: a behavioural frame model predicts every
// serial bit, the tx_done cycle and FIFO occupancy; builds with or without TX_PARITY_EN.
module tb_uart_tx_sequencer;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic       two_stop;
    logic       odd_parity;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx_out;
    logic       busy;
    logic [2:0] fifo_count;
    logic       tx_done;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    uart_tx_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .two_stop   (two_stop),
        .odd_parity (odd_parity),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .fifo_count (fifo_count),
        .tx_done    (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected line levels of one frame, one entry per serial bit.
    function automatic int frame_bits(input logic [7:0] b, input logic ts, input logic op,
                                      output logic [15:0] bits);
        int n = 0;
        bits = '0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = b[i];
            n++;
        end
        if (PAR_BITS == 1) begin
            bits[n] = 1'(($countones(b) + int'(op)) % 2);
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (ts) begin
            bits[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    task automatic push_byte(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_start();
        int t = 0;
        while (busy !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("start_timeout", 32'(busy === 1'b1), 1);
    endtask

    // Entered on the first cycle of START; returns on the cycle after the last stop bit.
    task automatic expect_frame(input logic [7:0] b, input logic ts, input logic op, input logic more);
        logic [15:0] bits;
        int nb;
        int len;
        nb  = frame_bits(b, ts, op, bits);
        len = nb * CLK_DIV;
        for (int i = 0; i < len; i++) begin
            check("tx_bit", tx_out, bits[i / CLK_DIV]);
            check("busy_in_frame", busy, 1);
            if (i != 0) check("tx_done_early", tx_done, 0);
            @(negedge clk);
        end
        check("tx_done_end", tx_done, 1);
        check("busy_after", busy, more);
        if (!more) check("tx_idle_after", tx_out, 1);
        $display("frame byte=%02h two_stop=%0d odd=%0d bits=%0d cycles=%0d", b, ts, op, nb, len);
    endtask

    task automatic single(input logic [7:0] d, input logic ts, input logic op);
        tx_en      = 1'b1;
        two_stop   = ts;
        odd_parity = op;
        push_byte(d);
        wait_start();
        expect_frame(d, ts, op, 1'b0);
        check("fifo_empty_after", fifo_count, 0);
    endtask

    // Fill with tx_en low (overflow dropped), then release as back-to-back frames.
    task automatic burst(input int n);
        logic [7:0] d;
        logic ts;
        logic op;
        tx_en      = 1'b0;
        ts         = 1'($urandom_range(0, 1));
        op         = 1'($urandom_range(0, 1));
        two_stop   = ts;
        odd_parity = op;
        model_q.delete();
        for (int k = 0; k < n; k++) begin
            d = 8'($urandom);
            check("wr_ready_fill", wr_ready, 32'(model_q.size() != FIFO_DEPTH));
            if (model_q.size() < FIFO_DEPTH) model_q.push_back(d);
            push_byte(d);
        end
        check("fifo_count_filled", fifo_count, model_q.size());
        check("wr_ready_filled", wr_ready, 32'(model_q.size() != FIFO_DEPTH));
        repeat (3) @(negedge clk);
        check("busy_disabled", busy, 0);
        // A push offered on the popping edge of a full FIFO must still be dropped.
        tx_en    = 1'b1;
        wr_valid = (model_q.size() == FIFO_DEPTH);
        wr_data  = 8'hEE;
        @(negedge clk);
        wr_valid = 1'b0;
        wait_start();
        check("fifo_count_first_pop", fifo_count, model_q.size() - 1);
        while (model_q.size() != 0) begin
            d = model_q.pop_front();
            expect_frame(d, ts, op, 1'(model_q.size() != 0));
        end
        check("fifo_count_drained", fifo_count, 0);
    endtask

    task automatic mid_frame_change();
        logic [7:0] b0;
        logic [7:0] b1;
        logic ts;
        logic op;
        logic ts2;
        logic op2;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        ts = 1'($urandom_range(0, 1));
        op = 1'($urandom_range(0, 1));
        tx_en      = 1'b1;
        two_stop   = ts;
        odd_parity = op;
        push_byte(b0);
        push_byte(b1);
        wait_start();
        check("fifo_push_pop_same", fifo_count, 1);
        fork
            expect_frame(b0, ts, op, 1'b0);
            begin
                repeat (10) @(negedge clk);
                odd_parity = ~op;
                two_stop   = ~ts;
                tx_en      = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("held_busy", busy, 0);
        check("held_fifo_count", fifo_count, 1);
        check("held_tx_out", tx_out, 1);
        ts2 = 1'($urandom_range(0, 1));
        op2 = 1'($urandom_range(0, 1));
        two_stop   = ts2;
        odd_parity = op2;
        tx_en      = 1'b1;
        wait_start();
        expect_frame(b1, ts2, op2, 1'b0);
    endtask

    task automatic reset_mid_frame();
        logic [7:0] b0;
        logic [15:0] bits;
        int nb;
        b0 = 8'($urandom);
        tx_en      = 1'b1;
        two_stop   = 1'b0;
        odd_parity = 1'b1;
        nb = frame_bits(b0, 1'b0, 1'b1, bits);
        push_byte(b0);
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        repeat (17) @(negedge clk);
        check("pre_reset_data_bit3", tx_out, bits[4]);
        check("pre_reset_fifo_count", fifo_count, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_tx_out", tx_out, 1);
        check("abort_busy", busy, 0);
        check("abort_fifo_count", fifo_count, 0);
        check("abort_tx_done", tx_done, 0);
        check("abort_wr_ready", wr_ready, 1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("abort_no_done", tx_done, 0);
        end
        check("abort_idle_busy", busy, 0);
        $display("reset abort frame_bits=%0d", nb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        tx_en      = 1'b0;
        two_stop   = 1'b0;
        odd_parity = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_tx_out", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_wr_ready", wr_ready, 1);

        single(8'h55, 1'b0, 1'b1);
        single(8'h07, 1'b1, 1'b0);
        single(8'hA0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            single(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        burst(5);
        for (int k = 0; k < 3; k++) begin
            burst(int'($urandom_range(1, 4)));
        end
        mid_frame_change();
        reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Buffers bytes written by the core and sequences UART transmit frames on a single serial line. Frame shape comes from the control/status register bits: enable, two-stop and odd-parity. Sits between the memory-mapped UART register file and the tx pin. Contains a small FIFO, a baud-rate divider and the frame FSM.

Parameters:
CLK_DIV, 16, clk cycles per serial bit (integer >= 2)
FIFO_DEPTH, 4, byte entries in the TX FIFO (power of 2, >= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tx_en  input  1  transmit enable from control/status register
two_stop  input  1  1 = two stop bits, 0 = one stop bit
odd_parity  input  1  1 = odd parity, 0 = even parity
wr_valid  input  1  byte push request
wr_data  input  8  byte to push
wr_ready  output  1  FIFO can accept a byte
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress (FSM not IDLE)
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
tx_done  output  1  one-cycle pulse at end of each frame

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values: tx_out=1, busy=0, tx_done=0, fifo_count=0, wr_ready=1, FSM=IDLE, baud counter=0. FIFO pointers cleared; contents don't care.
- Reset mid-frame aborts the frame. tx_out is 1 from the next edge. Buffered bytes are discarded.
- FIFO push: occurs when wr_valid && wr_ready.
  - wr_ready = (fifo_count != FIFO_DEPTH), taken from registered count.
  - No push while full, even in the same cycle as a pop.
  - A push while wr_ready=0 is dropped silently.
  - Simultaneous push and pop leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: if tx_en && fifo_count!=0:
  - pop head into shift register;
  - latch two_stop and odd_parity into frame-config registers;
  - compute parity = ^data XOR odd_parity (even: count of ones incl. parity is even; odd: odd);
  - go to START. Baud counter is reset to 0.
- Each non-IDLE state holds for exactly CLK_DIV cycles. The baud counter counts 0..CLK_DIV-1 and advances state on terminal count.
- tx_out per state:
  - START = 0;
  - DATA = shift[0], LSB first, shift right each bit, 8 bits tracked by a 3-bit index;
  - PARITY = latched parity;
  - STOP1/STOP2 = 1;
  - IDLE = 1.
- Transitions:
  - START -> DATA.
  - DATA (after bit 7) -> PARITY.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if latched two_stop, else end.
  - STOP2 -> end.
- End of frame: tx_done=1 for one cycle on the terminal baud count of the last stop bit. If tx_en && FIFO non-empty, pop next byte and go directly to START in the same edge (no idle gap). Otherwise go to IDLE.
- Config changes and tx_en deassertion mid-frame do not affect the current frame. Deasserting tx_en stops new frames after the current one completes. Bytes stay buffered.
- busy = (state != IDLE).
- Frame length in cycles = CLK_DIV * (10 + P + S), where P = parity bit present (1), S = 1 if two_stop.

Optional Feature:
TX_PARITY_EN:
- Defined: the PARITY state exists and odd_parity is honoured as above.
- Undefined: the PARITY state and parity logic are not built; DATA -> STOP1 directly; odd_parity is ignored; P=0 in the frame-length formula.

Test Plan:
- CLK_DIV=4, TX_PARITY_EN defined, tx_en=1, odd_parity=1, two_stop=0, push 0x55 -> tx_out sequence 0,1,0,1,0,1,0,1,0,1(parity),1(stop), each held 4 cycles; tx_done pulses 44 cycles after START entry; busy low after.
- Same config with two_stop=1, odd_parity=0, push 0x07 -> parity bit 1, two stop bits, frame 48 cycles.
- tx_en=0, push 5 bytes with FIFO_DEPTH=4 -> first 4 accepted, fifo_count=4, wr_ready=0, 5th dropped; raise tx_en -> 4 back-to-back frames with no idle gap, 4 tx_done pulses, fifo_count reaches 0.
- Mid-frame toggle odd_parity and deassert tx_en during DATA with 2 bytes queued -> current frame keeps latched parity; no second frame; fifo_count=1; tx_out=1.
- Assert reset during DATA bit 3 with 2 bytes queued -> next cycle tx_out=1, busy=0, fifo_count=0, tx_done never pulses.
- TX_PARITY_EN undefined, CLK_DIV=4, push 0xA0 -> 0,0,0,0,0,0,1,0,1,1; frame 40 cycles.
